data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving cycles from request acceptance to resp_valid; legal range 1..8.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words; power of two.
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the pipeline MEM stage presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1, where 1 means store and 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data.
REQ-010 The block SHALL have port req_wstrb, input, 4, the store byte-lane enables; bit i enables byte i.
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a response is presented.
REQ-012 The block SHALL have port resp_ready, input, 1, meaning the requester consumes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32, the load data.
REQ-014 The block SHALL have port resp_err, output, 1, the access error flag.

Function
REQ-015 The block SHALL implement a three-state machine with states IDLE, BUSY and RESP.
REQ-016 The block SHALL drive req_ready=1 only in IDLE and req_ready=0 in BUSY and RESP.
REQ-017 In IDLE, on req_valid=1, the block SHALL capture we, addr, wdata and wstrb, load a latency counter with LATENCY, and go to BUSY.
REQ-018 In BUSY, the block SHALL decrement the counter each cycle, and at the edge where the counter reaches 0 it SHALL perform the access, set resp_valid=1 and go to RESP.
REQ-019 For a request accepted at edge T, resp_valid SHALL first be 1 after edge T+LATENCY.
REQ-020 The block SHALL index storage with word address addr[log2(DEPTH_WORDS)+1:2].
REQ-021 A store SHALL update only the byte lanes enabled in wstrb, at the same edge resp_valid rises.
REQ-022 A store with wstrb=0 SHALL complete normally with no storage change.
REQ-023 A store response SHALL drive resp_rdata=0.
REQ-024 A load response SHALL return the full stored word; byte/halfword extraction is the requester's job.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1.
REQ-026 On the resp_valid&resp_ready edge, the block SHALL clear resp_valid and return to IDLE.
REQ-027 A new request SHALL NOT be accepted in the cycle of the response handshake, giving a minimum spacing of LATENCY+2 cycles between accepts.
REQ-028 req_valid asserted outside IDLE SHALL be ignored, and the requester SHALL hold the request until req_ready=1.
REQ-029 Storage SHALL initialise to all zeros at simulation start.

Reset
REQ-030 Asynchronous reset SHALL force the state to IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and the counter to 0.
REQ-031 Reset in BUSY SHALL abort the pending access, leaving storage unmodified if the write edge has not occurred.
REQ-032 Reset SHALL NOT clear the storage contents.

Configuration
REQ-033 With macro DMEM_ERR_CHECK_EN defined, an address with addr[1:0]!=0 or addr at or above DEPTH_WORDS*4 SHALL complete with resp_err=1 and resp_rdata=0, and SHALL cause no storage write.
REQ-034 With macro DMEM_ERR_CHECK_EN undefined, resp_err SHALL be constant 0, addr[1:0] and out-of-range upper bits SHALL be ignored, and the address SHALL wrap modulo DEPTH_WORDS.

Verification
REQ-035 Store addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, then load 0x10 -> load resp_rdata=0xDEADBEEF, resp_err=0.
REQ-036 LATENCY=3, accept at edge T -> resp_valid first 1 after T+3; req_ready=0 from T to the handshake.
REQ-037 Word 0x20 holds 0x11223344, store wdata=0xAABBCCDD with wstrb=0x5 -> reload returns 0x11BB33DD.
REQ-038 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable throughout, and a new req_valid is ignored.
REQ-039 Store to 0x40 with reset asserted in BUSY -> outputs return to reset values and a later load of 0x40 returns the old value.
REQ-040 With DMEM_ERR_CHECK_EN, load 0x13 -> resp_err=1, resp_rdata=0; without the macro, the same load returns the word at 0x10 with resp_err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the MEM stage: one request in flight, byte-lane stores.
// Optional address checking is enabled with macro DMEM_ERR_CHECK_EN.
module data_mem_responder #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        mem_we_s;
   logic        addr_err_s;
   logic [AW-1:0] idx_s;
   logic [31:0] rd_word_s;

   // Storage is not touched by reset, so it starts from zero once at elaboration.
   logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0000_0000};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

   assign idx_s     = addr_q[AW+1:2];
   assign rd_word_s = mem_q[idx_s];

`ifdef DMEM_ERR_CHECK_EN
   assign addr_err_s = (addr_q[1:0] != 2'b00) ||
                       ({1'b0, addr_q} >= (33'(DEPTH_WORDS) << 2));
`else
   logic addr_unused_s;
   assign addr_unused_s = ^{addr_q[31:AW+2], addr_q[1:0]};
   assign addr_err_s    = 1'b0;
`endif

   // Next-state, request capture and response generation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               cnt_d   = 4'(LATENCY);
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // The counter hits zero on this edge: perform the access now.
            if (cnt_q <= 4'd1) begin
               cnt_d        = 4'd0;
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = addr_err_s;
               mem_we_s     = we_q && !addr_err_s;
               if (we_q || addr_err_s) begin
                  resp_rdata_d = 32'h0000_0000;
               end else begin
                  resp_rdata_d = rd_word_s;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         wstrb_q      <= 4'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Byte-lane store into storage.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[idx_s] <= merge_bytes(mem_q[idx_s], wdata_q, wstrb_q);
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
